serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Multi-cycle sequencer that computes a WIDTH-bit add or subtract by driving a 2-bit adder slice (with carry-in) once per cycle, LSB pair first. It carries between slices through an internal carry register. It sits between an issuing requester and a consumer on valid/ready handshakes, and is the area-minimal ALU add path. Each result is held until the consumer accepts it.

## Interface
- WIDTH, 8: operand width in bits; must be even and ≥ 2. SLICES = WIDTH/2.
- clk  in  1  rising-edge clock; sole clock domain.
- rst_n  in  1  active-low, synchronous reset. Sampled on the clk rising edge only.
- in_valid  in  1  requester presents an operation.
- in_ready  out  1  block can accept; equals (state == IDLE) && rst_n.
- a  in  WIDTH  operand A; sampled at accept.
- b  in  WIDTH  operand B; sampled at accept.
- sub  in  1  0 = A+B, 1 = A−B; sampled at accept.
- out_valid  out  1  result registers hold a finished operation.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  sum/difference modulo 2^WIDTH.
- carry_out  out  1  final carry. For subtract: 1 = no borrow.
- overflow  out  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE. Encoding is 2 bits.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a, b^{WIDTH{sub}}, carry_reg=sub, slice count=0, then go to RUN.
- RUN:
  - Each cycle, the slice adds bits [2k+1:2k] of A and B' with carry_reg. The 2 sum bits go into the result register at the same position; the slice carry goes into carry_reg.
  - k increments each cycle.
  - On the cycle k == SLICES−1: capture carry_out from the slice carry-out and overflow = c_in(MSB) ^ c_out(MSB), set out_valid, go to DONE.
  - in_valid is ignored in RUN.
- DONE:
  - out_valid=1. result, carry_out and overflow are held stable.
  - On out_ready: clear out_valid and go to IDLE.
  - A new operation is never accepted in the same cycle as the result handshake.
- Arithmetic:
  - Result is exactly (a + (sub ? ~b : b) + sub) mod 2^WIDTH.
  - carry_out is bit WIDTH of that sum.
  - The operand registers are not modified by in_valid or a changes after accept.
- Reset values:
  - state=IDLE, out_valid=0, result=0, carry_out=0, overflow=0, carry_reg=0, k=0.
  - in_ready=0 while rst_n=0, and 1 from the first cycle after release.
- Reset mid-operation (RUN or DONE) aborts: partial or unaccepted results are discarded and no out_valid pulse is produced.
- out_ready while out_valid=0 has no effect.

## Timing
- Accept edge E0. Slices are processed on edges E1..E_SLICES. out_valid is high after edge E_SLICES.
- Latency (accept to out_valid) is SLICES cycles; it is 4 cycles for WIDTH=8.
- Minimum issue interval is SLICES+2 cycles: SLICES RUN cycles, ≥1 DONE cycle and 1 IDLE cycle.
- All outputs are registered except in_ready, which is decoded from state and rst_n only, with no input-to-output combinational path.
- Result bits [2k+1:2k] become valid after edge E_{k+1}. Consumers read result only while out_valid=1.

## Structure
- Shared package/include `serial_adder_pkg` holds:
  - state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the SLICES derivation;
  - a WIDTH-even check, which is an elaboration error if WIDTH is odd.
- One sub-module, `adder_2bit_cin`:
  - ports (a[1:0], b[1:0], carry_in, sum[1:0], carry_out, carry_mid);
  - built from two existing `full_adder` instances;
  - carry_mid exposes the internal carry so overflow can be computed.
- The controller contains the FSM, slice counter ($clog2(SLICES) bits, minimum 1), operand/result shift or index muxing, and handshake logic.
- Formal properties under `ifdef FORMAL`:
  - when out_valid=1, result equals the reference arithmetic on the latched operands;
  - out_valid never rises except from RUN;
  - in_ready && out_valid is never true.

## Test plan
- WIDTH=8, a=200, b=100, sub=0 → out_valid exactly 4 cycles after accept; result=0x2C, carry_out=1, overflow=0.
- a=5, b=7, sub=1 → result=0xFE, carry_out=0 (borrow), overflow=0. Then a=7, b=5, sub=1 → 0x02, carry_out=1.
- a=0x7F, b=0x01, sub=0 → result=0x80, overflow=1, carry_out=0. Also a=0x80, b=0x01, sub=1 → 0x7F, overflow=1.
- Backpressure: hold out_ready=0 for 10 cycles → out_valid, result and flags are stable; in_ready=0 throughout; in_valid pulses with new operands are ignored. Then raise out_ready → in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst_n=0 for 1 cycle after E2 → all outputs zero, no out_valid. A following op a=1, b=1 gives result=0x02 with normal latency.
- Randomized sweep, WIDTH=8 and WIDTH=2, ≥1000 ops with random handshake stalls → every result/carry/overflow matches the reference model.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial add/subtract sequencer: state encoding,
// slice-count derivation and the operand-width legality check.
package serial_adder_pkg;

    localparam logic [1:0] IDLE_ENC = 2'd0;
    localparam logic [1:0] RUN_ENC  = 2'd1;
    localparam logic [1:0] DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        IDLE = IDLE_ENC,
        RUN  = RUN_ENC,
        DONE = DONE_ENC
    } state_t;

    function automatic int slices_of(input int width);
        return width / 2;
    endfunction

    // The slice counter is never narrower than one bit, even for a single slice.
    function automatic int count_width(input int slices);
        return (slices > 1) ? $clog2(slices) : 1;
    endfunction

    function automatic bit width_ok(input int width);
        return (width >= 2) && ((width % 2) == 0);
    endfunction

endpackage

// File: rtl/adder_2bit_cin.sv
// Two-bit ripple slice; carry_mid is the carry into the upper bit, which the
// controller needs to detect signed overflow on the most significant slice.
module adder_2bit_cin (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       carry_in,
    output logic [1:0] sum,
    output logic       carry_out,
    output logic       carry_mid
);

    full_adder u_fa_lo (
        .a    (a[0]),
        .b    (b[0]),
        .cin  (carry_in),
        .sum  (sum[0]),
        .cout (carry_mid)
    );

    full_adder u_fa_hi (
        .a    (a[1]),
        .b    (b[1]),
        .cin  (carry_mid),
        .sum  (sum[1]),
        .cout (carry_out)
    );

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used as the building block of the 2-bit slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Serial WIDTH-bit add/subtract: one 2-bit slice per cycle, LSB pair first,
// with valid/ready handshakes on both the request and the result side.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int SLICES = slices_of(WIDTH);
    localparam int KW     = count_width(SLICES);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("serial_adder_ctrl: WIDTH must be even and >= 2");
    end

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_valid is only looked at in IDLE; out_valid stays high until out_ready.
    state_t           state, state_next;
    logic [WIDTH-1:0] op_a, op_b;
    logic             carry_reg;
    logic [KW-1:0]    k;
    logic [KW:0]      bit_idx;
    logic [1:0]       slice_sum;
    logic             slice_cout, slice_cmid;
    logic             last_slice, accept;

    assign in_ready   = (state == IDLE) && rst_n;
    assign accept     = in_valid && in_ready;
    assign bit_idx    = {k, 1'b0};
    assign last_slice = (k == KW'(SLICES - 1));

    adder_2bit_cin u_slice (
        .a         (op_a[bit_idx +: 2]),
        .b         (op_b[bit_idx +: 2]),
        .carry_in  (carry_reg),
        .sum       (slice_sum),
        .carry_out (slice_cout),
        .carry_mid (slice_cmid)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)     state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            carry_reg <= 1'b0;
            k         <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    // Subtract is A + ~B + 1: invert B here and seed the carry.
                    if (accept) begin
                        op_a      <= a;
                        op_b      <= b ^ {WIDTH{sub}};
                        carry_reg <= sub;
                        k         <= '0;
                    end
                end
                RUN: begin
                    result[bit_idx +: 2] <= slice_sum;
                    carry_reg            <= slice_cout;
                    k                    <= k + KW'(1);
                    if (last_slice) begin
                        carry_out <= slice_cout;
                        overflow  <= slice_cmid ^ slice_cout;
                        out_valid <= 1'b1;
                        k         <= '0;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef FORMAL
    logic sub_q;

    always_ff @(posedge clk) begin
        if (!rst_n)      sub_q <= 1'b0;
        else if (accept) sub_q <= sub;
    end

    always @(posedge clk) begin
        if (rst_n && out_valid)
            assert ({carry_out, result} == ({1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, sub_q}));
        if (rst_n && $past(rst_n) && out_valid && !$past(out_valid))
            assert ($past(state) == RUN);
        assert (!(in_ready && out_valid));
    end
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl at WIDTH=8 and WIDTH=2: directed arithmetic,
// latency, backpressure, mid-operation reset and randomized sweeps.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       in_valid = 1'b0, sub = 1'b0, out_ready = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       in_ready, out_valid, carry_out, overflow;
    logic [7:0] result;

    logic       in_valid_w2 = 1'b0, sub_w2 = 1'b0, out_ready_w2 = 1'b0;
    logic [1:0] a_w2 = '0, b_w2 = '0;
    logic       in_ready_w2, out_valid_w2, carry_out_w2, overflow_w2;
    logic [1:0] result_w2;

    int n_checks = 0;
    int n_errors = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out), .overflow(overflow)
    );

    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w2), .in_ready(in_ready_w2),
        .a(a_w2), .b(b_w2), .sub(sub_w2), .out_valid(out_valid_w2), .out_ready(out_ready_w2),
        .result(result_w2), .carry_out(carry_out_w2), .overflow(overflow_w2)
    );

    // Reference: plain integer arithmetic; returns {overflow, carry_out, result[7:0]}.
    function automatic logic [9:0] ref_op(input int w, input int xa, input int xb, input bit xs);
        int m, r_u, sa, sb, rs;
        bit co, ov;
        logic [9:0] pk;
        m   = 1 << w;
        r_u = xs ? (xa - xb + m) : (xa + xb);
        co  = xs ? (xa >= xb) : ((xa + xb) >= m);
        sa  = (xa >= m / 2) ? xa - m : xa;
        sb  = (xb >= m / 2) ? xb - m : xb;
        rs  = xs ? (sa - sb) : (sa + sb);
        ov  = (rs < -(m / 2)) || (rs > (m / 2 - 1));
        pk  = {ov, co, 8'(r_u % m)};
        return pk;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op on the 8-bit DUT, wait for the result, hold it out_stall cycles, then accept it.
    task automatic drive_op8(input logic [7:0] xa, input logic [7:0] xb, input bit xs,
                             input int out_stall, output logic [9:0] got, output int lat,
                             output bit timed_out);
        int n;
        timed_out = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        in_valid = 1'b1; a = xa; b = xb; sub = xs;
        tick();
        in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        if (!out_valid) begin
            timed_out = 1'b1;
            got = '0;
            return;
        end
        got = {overflow, carry_out, result};
        repeat (out_stall) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic drive_op2(input logic [1:0] xa, input logic [1:0] xb, input bit xs,
                             input int out_stall, output logic [9:0] got, output bit timed_out);
        int n;
        timed_out = 1'b0;
        n = 0;
        while (!in_ready_w2 && n < 20) begin tick(); n++; end
        in_valid_w2 = 1'b1; a_w2 = xa; b_w2 = xb; sub_w2 = xs;
        tick();
        in_valid_w2 = 1'b0;
        n = 0;
        while (!out_valid_w2 && n < 20) begin tick(); n++; end
        if (!out_valid_w2) begin
            timed_out = 1'b1;
            got = '0;
            return;
        end
        got = {overflow_w2, carry_out_w2, 6'd0, result_w2};
        repeat (out_stall) tick();
        out_ready_w2 = 1'b1;
        tick();
        out_ready_w2 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready);
        end
        n_checks++;
        if ({out_valid, carry_out, overflow, result} !== 11'd0) begin
            n_errors++;
            $display("FAIL reset_outputs got=%b%b%b %h want=000 00", out_valid, carry_out, overflow, result);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || in_ready_w2 !== 1'b1) begin
            n_errors++; $display("FAIL reset_release_ready got=%b%b want=11", in_ready, in_ready_w2);
        end
    endtask

    task automatic test_directed();
        logic [7:0] ta[5] = '{8'd200, 8'd5,  8'd7,  8'h7F, 8'h80};
        logic [7:0] tb[5] = '{8'd100, 8'd7,  8'd5,  8'h01, 8'h01};
        bit         ts[5] = '{1'b0,   1'b1,  1'b1,  1'b0,  1'b1};
        logic [9:0] te[5] = '{{2'b01, 8'h2C}, {2'b00, 8'hFE}, {2'b01, 8'h02},
                              {2'b10, 8'h80}, {2'b11, 8'h7F}};
        logic [9:0] got;
        int lat;
        bit to;
        for (int i = 0; i < 5; i++) begin
            drive_op8(ta[i], tb[i], ts[i], 0, got, lat, to);
            n_checks++;
            if (to) begin
                n_errors++; $display("FAIL directed_timeout op=%0d no out_valid within 20 cycles", i);
                continue;
            end
            n_checks++;
            if (lat !== 4) begin
                n_errors++; $display("FAIL directed_latency op=%0d got=%0d want=4", i, lat);
            end
            n_checks++;
            if (got !== te[i]) begin
                n_errors++; $display("FAIL directed_result op=%0d got=%h want=%h", i, got, te[i]);
            end
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL directed_handshake op=%0d out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] want, got;
        int n;
        bit bad;
        want = ref_op(8, 150, 77, 1'b1);
        while (!in_ready) tick();
        in_valid = 1'b1; a = 8'd150; b = 8'd77; sub = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        n_checks++;
        if (!out_valid) begin
            n_errors++; $display("FAIL backpressure_timeout no out_valid within 20 cycles");
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
            tick();
            got = {overflow, carry_out, result};
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || got !== want) begin
                n_errors++; bad = 1'b1;
                $display("FAIL backpressure_hold cyc=%0d out_valid=%b in_ready=%b got=%h want=1/0/%h",
                         i, out_valid, in_ready, got, want);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL backpressure_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL backpressure_no_spurious out_valid=%b want=0", out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [9:0] got;
        int lat;
        bit to, seen;
        while (!in_ready) tick();
        in_valid = 1'b1; a = 8'hA5; b = 8'h3C; sub = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++; $display("FAIL midreset_in_ready got=%b want=0", in_ready);
        end
        tick();
        rst_n = 1'b1;
        n_checks++;
        if ({out_valid, carry_out, overflow, result} !== 11'd0) begin
            n_errors++;
            $display("FAIL midreset_outputs got=%b%b%b %h want=000 00", out_valid, carry_out, overflow, result);
        end
        seen = 1'b0;
        repeat (6) begin tick(); if (out_valid) seen = 1'b1; end
        n_checks++;
        if (seen) begin
            n_errors++; $display("FAIL midreset_no_valid got out_valid=1 want=0");
        end
        drive_op8(8'd1, 8'd1, 1'b0, 0, got, lat, to);
        n_checks++;
        if (to || lat !== 4 || got !== {2'b00, 8'h02}) begin
            n_errors++; $display("FAIL midreset_next_op timeout=%b lat=%0d got=%h want lat=4 res=002", to, lat, got);
        end
    endtask

    task automatic test_random_w8();
        logic [9:0] got, want;
        logic [7:0] xa, xb;
        bit xs, to;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            xa = 8'($urandom); xb = 8'($urandom); xs = 1'($urandom);
            exp_q.push_back(ref_op(8, int'(xa), int'(xb), xs));
            repeat ($urandom_range(0, 2)) tick();
            drive_op8(xa, xb, xs, $urandom_range(0, 3), got, lat, to);
            want = exp_q.pop_front();
            n_checks++;
            if (to || lat !== 4 || got !== want) begin
                n_errors++;
                $display("FAIL random_w8 op=%0d a=%h b=%h sub=%b timeout=%b lat=%0d got=%h want=%h",
                         i, xa, xb, xs, to, lat, got, want);
            end
        end
    endtask

    task automatic test_random_w2();
        logic [9:0] got, want;
        logic [1:0] xa, xb;
        bit xs, to;
        for (int i = 0; i < 500; i++) begin
            xa = 2'($urandom); xb = 2'($urandom); xs = 1'($urandom);
            want = ref_op(2, int'(xa), int'(xb), xs);
            exp_q.push_back({want[9:8], 6'd0, want[1:0]});
            repeat ($urandom_range(0, 2)) tick();
            drive_op2(xa, xb, xs, $urandom_range(0, 3), got, to);
            want = exp_q.pop_front();
            n_checks++;
            if (to || got !== want) begin
                n_errors++;
                $display("FAIL random_w2 op=%0d a=%h b=%h sub=%b timeout=%b got=%h want=%h",
                         i, xa, xb, xs, to, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random_w8();
        test_random_w2();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
